// File: rtl/vx_rop_dcr_bank.sv
// Multi-render-target ROP configuration store: DCR writes land in a bank that is
// published to VX_rop_unit on commit once the pipeline drains. Optional macro
// VX_ROP_DCR_SHADOW_EN enables the shadow (double-buffered) bank.
module vx_rop_dcr_bank #(
  parameter int NUM_RTS    = 4,
  parameter int PITCH_BITS = 16,
  parameter int EPOCH_BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dcr_wr_valid,
  output logic                      dcr_wr_ready,
  input  logic [7:0]                dcr_wr_addr,
  input  logic [31:0]               dcr_wr_data,
  output logic                      dcr_wr_err,
  input  logic                      commit_valid,
  output logic                      commit_ready,
  input  logic                      pipe_idle,
  output logic                      commit_done,
  output logic [EPOCH_BITS-1:0]     epoch,
  output logic [8*32-1:0]           glb_regs,
  output logic [NUM_RTS*6*32-1:0]   rt_regs
);

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_e;

  typedef struct packed {
    logic        mapped;
    logic [31:0] mask;
  } dec_t;

  // Writable-bit masks for each register word.
  localparam logic [31:0] M_FULL        = 32'hFFFF_FFFF;
  localparam logic [31:0] M_PITCH       = 32'((64'(1) << PITCH_BITS) - 64'(1));
  localparam logic [31:0] M_DEPTH       = 32'h0000_001F;
  localparam logic [31:0] M_STENCIL_CTL = 32'h0000_7FCF;
  localparam logic [31:0] M_STENCIL_REF = 32'h00FF_FFFF;
  localparam logic [31:0] M_LOGIC_OP    = 32'h0000_000F;
  localparam logic [31:0] M_CBUF_WMASK  = 32'h0000_000F;
  localparam logic [31:0] M_BLEND_MODE  = 32'h0000_0771;
  localparam logic [31:0] M_BLEND_FUNC  = 32'h0F0F_0F0F;

  // Globals live at 0x00-0x07; RT r occupies 0x10+8r .. 0x10+8r+5.
  function automatic dec_t decode(input logic [7:0] addr);
    dec_t       d;
    logic [4:0] rt;
    d.mapped = 1'b1;
    d.mask   = '0;
    rt       = addr[7:3] - 5'd2;
    if (addr[7:3] == 5'd0) begin
      case (addr[2:0])
        3'd0:         d.mask = M_FULL;
        3'd1:         d.mask = M_PITCH;
        3'd2:         d.mask = M_DEPTH;
        3'd3, 3'd4:   d.mask = M_STENCIL_CTL;
        3'd5, 3'd6:   d.mask = M_STENCIL_REF;
        default:      d.mask = M_LOGIC_OP;
      endcase
    end else if (addr[7:4] != 4'd0 && int'(rt) < NUM_RTS && addr[2:0] < 3'd6) begin
      case (addr[2:0])
        3'd1:    d.mask = M_PITCH;
        3'd2:    d.mask = M_CBUF_WMASK;
        3'd3:    d.mask = M_BLEND_MODE;
        3'd4:    d.mask = M_BLEND_FUNC;
        default: d.mask = M_FULL;
      endcase
    end else begin
      d.mapped = 1'b0;
    end
    return d;
  endfunction

  state_e      state;
  state_e      state_nxt;
  dec_t        wr_dec;
  logic        wr_fire;
  logic        commit_fire;
  logic [31:0] wr_word;

  logic [31:0] glb_act [8];
  logic [31:0] rt_act  [NUM_RTS][6];

  assign wr_dec      = decode(dcr_wr_addr);
  assign wr_fire     = dcr_wr_valid & dcr_wr_ready;
  assign wr_word     = dcr_wr_data & wr_dec.mask;
  assign commit_fire = (state == ST_PENDING) && pipe_idle;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      ST_IDLE:    if (commit_valid && commit_ready) state_nxt = ST_PENDING;
      ST_PENDING: if (pipe_idle)                    state_nxt = ST_IDLE;
      default:                                      state_nxt = ST_IDLE;
    endcase
  end

  // Writes and new commits are both held off while a commit waits to drain.
  always_comb begin
    commit_ready = (state == ST_IDLE);
    dcr_wr_ready = (state == ST_IDLE);
  end

  // ------------------------------------------------------- register banks
`ifdef VX_ROP_DCR_SHADOW_EN
  logic [31:0] glb_shd [8];
  logic [31:0] rt_shd  [NUM_RTS][6];

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the register arrays are cleared by reset because consumers rely on
    // an all-zero configuration after reset; they are flops, not RAM.
    if (!reset) begin
      for (int i = 0; i < 8; i++) glb_shd[i] <= '0;
      for (int r = 0; r < NUM_RTS; r++)
        for (int k = 0; k < 6; k++) rt_shd[r][k] <= '0;
    end else if (wr_fire && wr_dec.mapped) begin
      for (int i = 0; i < 8; i++)
        if (dcr_wr_addr == 8'(i)) glb_shd[i] <= wr_word;
      for (int r = 0; r < NUM_RTS; r++)
        for (int k = 0; k < 6; k++)
          if (dcr_wr_addr == 8'(16 + 8 * r + k)) rt_shd[r][k] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) glb_act[i] <= '0;
      for (int r = 0; r < NUM_RTS; r++)
        for (int k = 0; k < 6; k++) rt_act[r][k] <= '0;
    end else if (commit_fire) begin
      for (int i = 0; i < 8; i++) glb_act[i] <= glb_shd[i];
      for (int r = 0; r < NUM_RTS; r++)
        for (int k = 0; k < 6; k++) rt_act[r][k] <= rt_shd[r][k];
    end
  end
`else
  // Single bank: writes go straight to the active words; commit only drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) glb_act[i] <= '0;
      for (int r = 0; r < NUM_RTS; r++)
        for (int k = 0; k < 6; k++) rt_act[r][k] <= '0;
    end else if (wr_fire && wr_dec.mapped) begin
      for (int i = 0; i < 8; i++)
        if (dcr_wr_addr == 8'(i)) glb_act[i] <= wr_word;
      for (int r = 0; r < NUM_RTS; r++)
        for (int k = 0; k < 6; k++)
          if (dcr_wr_addr == 8'(16 + 8 * r + k)) rt_act[r][k] <= wr_word;
    end
  end
`endif

  // ------------------------------------------------------- status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epoch       <= '0;
      commit_done <= 1'b0;
      dcr_wr_err  <= 1'b0;
    end else begin
      if (commit_fire) epoch <= epoch + 1'b1;
      commit_done <= commit_fire;
      dcr_wr_err  <= wr_fire && !wr_dec.mapped;
    end
  end

  always_comb begin
    glb_regs = '0;
    rt_regs  = '0;
    for (int i = 0; i < 8; i++) glb_regs[32*i +: 32] = glb_act[i];
    for (int r = 0; r < NUM_RTS; r++)
      for (int k = 0; k < 6; k++) rt_regs[32*(6*r+k) +: 32] = rt_act[r][k];
  end

endmodule
